action_queue: RTL

- Event source for the game-control FSM.
- Merges one-cycle player key pulses with internally generated gravity (DOWN) and garbage-bar (BAR) timer events into a QSIZE-deep action FIFO of state_type codes.
- The game FSM pops one action per handshake while in WAIT.
- Also owns the COUNT_SEC round countdown and the time_up flag.

---
 rtl/action_queue_pkg.sv | 63 ++++++
 rtl/action_fifo.sv | 99 +++++++++
 rtl/action_queue.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/action_queue_pkg.sv
// Shared game-control types: state codes, action kinds in arbitration order,
// and default timing constants for the action queue.
package action_queue_pkg;

  typedef enum logic [7:0] {
    NONE       = 8'd0,
    INIT       = 8'd1,
    WAIT       = 8'd2,
    LEFT       = 8'd3,
    RIGHT      = 8'd4,
    DOWN       = 8'd5,
    DROP       = 8'd6,
    HOLD       = 8'd7,
    ROTATE     = 8'd8,
    ROTATE_REV = 8'd9,
    BAR        = 8'd10,
    GAME_OVER  = 8'd11
  } state_type;

  // Pending-bit index; lower index wins arbitration.
  typedef enum logic [2:0] {
    A_DOWN       = 3'd0,
    A_BAR        = 3'd1,
    A_DROP       = 3'd2,
    A_HOLD       = 3'd3,
    A_LEFT       = 3'd4,
    A_RIGHT      = 3'd5,
    A_ROTATE     = 3'd6,
    A_ROTATE_REV = 3'd7
  } action_t;

  localparam int ACT_NUM       = 8;
  localparam int DEF_QSIZE     = 16;
  localparam int DEF_SEC_TICK  = 25_000_000;
  localparam int DEF_COUNT_SEC = 60;
  localparam int CNT_W         = $clog2(DEF_QSIZE + 1);

  function automatic state_type action_code(input action_t a);
    state_type code;
    case (a)
      A_DOWN:       code = DOWN;
      A_BAR:        code = BAR;
      A_DROP:       code = DROP;
      A_HOLD:       code = HOLD;
      A_LEFT:       code = LEFT;
      A_RIGHT:      code = RIGHT;
      A_ROTATE:     code = ROTATE;
      A_ROTATE_REV: code = ROTATE_REV;
      default:      code = NONE;
    endcase
    return code;
  endfunction

  // Counter width for a modulo-n tick counter, never narrower than one bit.
  function automatic int tick_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/action_fifo.sv
// First-word-fall-through circular buffer of state codes with a registered
// head entry, occupancy count and synchronous flush.
module action_fifo
  import action_queue_pkg::*;
#(
  parameter int DEPTH = DEF_QSIZE,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  state_type     din,
  input  logic          pop,
  output state_type     dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_type         mem_r [DEPTH];
  logic [AW-1:0]     rd_ptr_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [CW-1:0]     count_r;
  state_type         head_r;

  logic              pop_s;
  logic              push_s;
  logic [AW-1:0]     rd_next_s;
  logic [AW-1:0]     wr_next_s;
  logic [CW-1:0]     count_next_s;
  state_type         head_next_s;
  logic              full_s;
  logic              empty_s;

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == {CW{1'b0}});

  // Accepted pop/push, next pointers, next occupancy and next head entry.
  always_comb begin
    pop_s        = pop & ~empty_s & ~flush;
    push_s       = push & ~flush & (~full_s | pop_s);
    rd_next_s    = rd_ptr_r;
    wr_next_s    = wr_ptr_r;
    count_next_s = count_r;
    head_next_s  = NONE;
    if (flush) begin
      rd_next_s    = {AW{1'b0}};
      wr_next_s    = {AW{1'b0}};
      count_next_s = {CW{1'b0}};
    end else begin
      rd_next_s = pop_s  ? rd_ptr_r + AW'(1) : rd_ptr_r;
      wr_next_s = push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + CW'(1);
        2'b01:   count_next_s = count_r - CW'(1);
        default: count_next_s = count_r;
      endcase
    end
    // The slot being written this cycle becomes the head when the queue was
    // empty, or when the single held entry is popped at the same time.
    if (count_next_s == {CW{1'b0}}) begin
      head_next_s = NONE;
    end else if (push_s && (wr_ptr_r == rd_next_s)) begin
      head_next_s = din;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // Storage, pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= NONE;
      end
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      head_r   <= NONE;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= din;
      end
      rd_ptr_r <= rd_next_s;
      wr_ptr_r <= wr_next_s;
      count_r  <= count_next_s;
      head_r   <= head_next_s;
    end
  end

  assign dout  = head_r;
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

endmodule

// File: rtl/action_queue.sv
// Action source for the game FSM: merges key pulses with gravity and garbage
// timers through a priority arbiter into a FWFT queue; owns the round countdown.
module action_queue
  import action_queue_pkg::*;
#(
  parameter int QSIZE     = DEF_QSIZE,
  parameter int SEC_TICK  = DEF_SEC_TICK,
  parameter int COUNT_SEC = DEF_COUNT_SEC,
  parameter int DOWN_TICK = SEC_TICK * 3,
  parameter int BAR_TICK  = SEC_TICK * 20
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           run,
  input  logic                           flush,
  input  logic [6:0]                     key_evt,
  output logic                           act_valid,
  output logic [7:0]                     act,
  input  logic                           act_ready,
  output logic [$clog2(QSIZE+1)-1:0]     count,
  output logic [$clog2(COUNT_SEC+1)-1:0] sec_left,
  output logic                           time_up
);

  localparam int CW = $clog2(QSIZE + 1);
  localparam int SW = $clog2(COUNT_SEC + 1);
  localparam int GW = tick_w(DOWN_TICK);
  localparam int BW = tick_w(BAR_TICK);
  localparam int TW = tick_w(SEC_TICK);

  logic [ACT_NUM-1:0] pending_r;
  logic [GW-1:0]      grav_cnt_r;
  logic [BW-1:0]      bar_cnt_r;
  logic [TW-1:0]      sec_cnt_r;
  logic [SW-1:0]      sec_left_r;
  logic               time_up_r;

  logic               adv_s;
  logic               down_stb_s;
  logic               bar_stb_s;
  logic               sec_stb_s;
  logic [ACT_NUM-1:0] key_req_s;
  logic [ACT_NUM-1:0] req_s;
  logic [ACT_NUM-1:0] win_onehot_s;
  logic [2:0]         win_idx_s;
  logic [ACT_NUM-1:0] pending_next_s;
  logic               can_push_s;
  logic               push_s;
  state_type          push_code_s;

  state_type          fifo_dout_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [CW-1:0]      fifo_count_s;

  assign adv_s      = run & ~time_up_r;
  assign down_stb_s = adv_s & (grav_cnt_r == GW'(DOWN_TICK - 1));
  assign bar_stb_s  = adv_s & (bar_cnt_r  == BW'(BAR_TICK - 1));
  assign sec_stb_s  = adv_s & (sec_cnt_r  == TW'(SEC_TICK - 1));

  // Key bits reordered into pending-index order; key DOWN shares the gravity bit.
  assign key_req_s = {key_evt[6], key_evt[5], key_evt[1], key_evt[0],
                      key_evt[4], key_evt[3], 1'b0,       key_evt[2]};

  assign req_s        = pending_r | key_req_s | {6'b000000, bar_stb_s, down_stb_s};
  assign win_onehot_s = req_s & (~req_s + 8'd1);
  assign can_push_s   = ~fifo_full_s | (~fifo_empty_s & act_ready);
  assign push_s       = (|req_s) & can_push_s & ~flush;
  assign push_code_s  = action_code(action_t'(win_idx_s));

  // Index of the lowest set request bit (the arbitration winner).
  always_comb begin
    win_idx_s = 3'd0;
    for (int i = 0; i < ACT_NUM; i++) begin
      win_idx_s = win_idx_s | (win_onehot_s[i] ? 3'(i) : 3'd0);
    end
  end

  // Losers and unserved requests stay pending; the winner's bit is released.
  always_comb begin
    pending_next_s = pending_r;
    if (flush) begin
      pending_next_s = {ACT_NUM{1'b0}};
    end else if (push_s) begin
      pending_next_s = req_s & ~win_onehot_s;
    end else begin
      pending_next_s = req_s;
    end
  end

  // Pending request register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r <= {ACT_NUM{1'b0}};
    end else begin
      pending_r <= pending_next_s;
    end
  end

  // Gravity, garbage-bar and one-second tick counters; all hold while paused or timed out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grav_cnt_r <= {GW{1'b0}};
      bar_cnt_r  <= {BW{1'b0}};
      sec_cnt_r  <= {TW{1'b0}};
    end else if (flush) begin
      grav_cnt_r <= {GW{1'b0}};
      bar_cnt_r  <= {BW{1'b0}};
      sec_cnt_r  <= {TW{1'b0}};
    end else if (adv_s) begin
      grav_cnt_r <= down_stb_s ? {GW{1'b0}} : grav_cnt_r + GW'(1);
      bar_cnt_r  <= bar_stb_s  ? {BW{1'b0}} : bar_cnt_r  + BW'(1);
      sec_cnt_r  <= sec_stb_s  ? {TW{1'b0}} : sec_cnt_r  + TW'(1);
    end else begin
      grav_cnt_r <= grav_cnt_r;
      bar_cnt_r  <= bar_cnt_r;
      sec_cnt_r  <= sec_cnt_r;
    end
  end

  // Round countdown with sticky time-up on the step into zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_left_r <= SW'(COUNT_SEC);
      time_up_r  <= 1'b0;
    end else if (flush) begin
      sec_left_r <= SW'(COUNT_SEC);
      time_up_r  <= 1'b0;
    end else if (sec_stb_s && (sec_left_r != {SW{1'b0}})) begin
      sec_left_r <= sec_left_r - SW'(1);
      time_up_r  <= time_up_r | (sec_left_r == SW'(1));
    end else begin
      sec_left_r <= sec_left_r;
      time_up_r  <= time_up_r;
    end
  end

  action_fifo #(
    .DEPTH (QSIZE),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push_s),
    .din     (push_code_s),
    .pop     (act_ready),
    .dout    (fifo_dout_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  assign act_valid = ~fifo_empty_s;
  assign act       = fifo_dout_s;
  assign count     = fifo_count_s;
  assign sec_left  = sec_left_r;
  assign time_up   = time_up_r;

endmodule
